// File: rtl/user_id_reader_if.sv
// ---------------------------------------------------------------------------
// user_id_reader_if
//   Bundles the user-project-ID reader's data and handshake signals.
//
//   mask_rev  [31:0]  tie-cell programmed user project ID
//   rd_req            parallel read request (level, 4-phase)
//   id_valid          parallel read acknowledge, id_data valid
//   id_data   [31:0]  captured ID (shadow register)
//   ser_start         request one serial frame
//   ser_out           serial line, idle high
//   ser_busy          serial engine occupied
//   ser_done          one-cycle pulse after the stop bit
//
//   master : drives the requests and mask_rev (system side / testbench)
//   slave  : the reader itself
// ---------------------------------------------------------------------------
interface user_id_reader_if;
    logic [31:0] mask_rev;
    logic        rd_req;
    logic        id_valid;
    logic [31:0] id_data;
    logic        ser_start;
    logic        ser_out;
    logic        ser_busy;
    logic        ser_done;

    modport master (
        output mask_rev, rd_req, ser_start,
        input  id_valid, id_data, ser_out, ser_busy, ser_done
    );

    modport slave (
        input  mask_rev, rd_req, ser_start,
        output id_valid, id_data, ser_out, ser_busy, ser_done
    );
endinterface

// File: rtl/user_id_reader.sv
// ---------------------------------------------------------------------------
// user_id_reader
//   Captures the 32-bit user project ID from mask_rev into a shadow register
//   and offers it two ways:
//     - parallel: 4-phase rd_req / id_valid handshake, id_data = shadow
//     - serial:   one frame on ser_out per ser_start:
//                 start(0), shadow[31]..shadow[0], [parity], stop(1),
//                 every bit CLK_DIV clk cycles long
//
//   Parameters
//     CLK_DIV   serial bit period in clk cycles (1..255)
//
//   Ports
//     clk       rising-edge clock
//     reset     asynchronous, active-high reset
//     bus       user_id_reader_if.slave (mask_rev, rd_req, id_valid, id_data,
//               ser_start, ser_out, ser_busy, ser_done)
//
//   Build option
//     USER_ID_PARITY_EN  when defined, an even-parity bit (XOR of the shadow)
//                        is sent between the last data bit and the stop bit.
// ---------------------------------------------------------------------------
module user_id_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    user_id_reader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_SHIFT,
`ifdef USER_ID_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [31:0] r_shadow;
    logic [7:0]  r_div;       // cycles spent in the current bit
    logic [5:0]  r_bit;       // data bits already sent
    logic        r_serial;    // CAPTURE was entered for a serial frame
    logic        r_id_valid;
    logic        r_ser_out;
    logic        r_busy;
    logic        r_done;

    logic        w_div_end;
    logic [4:0]  w_next_idx;

    assign w_div_end  = (r_div == DIV_LAST);
    // Data bits go out MSB first: after r_bit bits, the next one is 30-r_bit.
    assign w_next_idx = 5'd30 - r_bit[4:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shadow   <= '0;
            r_div      <= '0;
            r_bit      <= '0;
            r_serial   <= 1'b0;
            r_id_valid <= 1'b0;
            r_ser_out  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    r_bit <= '0;
                    // ser_start has priority; a rd_req held alongside it is
                    // picked up on return to IDLE because it is level-held.
                    if (bus.ser_start) begin
                        r_state  <= S_CAPTURE;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (bus.rd_req) begin
                        r_state  <= S_CAPTURE;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                S_CAPTURE: begin
                    r_shadow <= bus.mask_rev;
                    if (r_serial) begin
                        r_state   <= S_START;
                        r_ser_out <= 1'b0;
                    end else begin
                        r_state    <= S_HOLD;
                        r_id_valid <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_div_end) begin
                        r_div     <= '0;
                        r_state   <= S_SHIFT;
                        r_ser_out <= r_shadow[31];
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        r_bit <= r_bit + 6'd1;
                        if (r_bit == 6'd31) begin
`ifdef USER_ID_PARITY_EN
                            r_state   <= S_PARITY;
                            r_ser_out <= ^r_shadow;
`else
                            r_state   <= S_STOP;
                            r_ser_out <= 1'b1;
`endif
                        end else begin
                            r_ser_out <= r_shadow[w_next_idx];
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

`ifdef USER_ID_PARITY_EN
                S_PARITY: begin
                    if (w_div_end) begin
                        r_div     <= '0;
                        r_state   <= S_STOP;
                        r_ser_out <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_HOLD: begin
                    if (!bus.rd_req) begin
                        r_id_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.id_data  = r_shadow;
    assign bus.id_valid = r_id_valid;
    assign bus.ser_out  = r_ser_out;
    assign bus.ser_busy = r_busy;
    assign bus.ser_done = r_done;

endmodule

// File: tb/tb_user_id_reader.sv
module tb_user_id_reader;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    user_id_reader_if ifa();
    user_id_reader_if ifb();

    user_id_reader #(.CLK_DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    user_id_reader #(.CLK_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

`ifdef USER_ID_PARITY_EN
    localparam int FRAME_BITS = 35;
`else
    localparam int FRAME_BITS = 34;
`endif

    // Serial monitor follows whichever instance sel picks.
    int   sel = 0;
    logic m_ser_out, m_busy, m_done;
    assign m_ser_out = (sel == 0) ? ifa.ser_out  : ifb.ser_out;
    assign m_busy    = (sel == 0) ? ifa.ser_busy : ifb.ser_busy;
    assign m_done    = (sel == 0) ? ifa.ser_done : ifb.ser_done;

    typedef struct {
        logic [31:0] word;
        int          div;
    } frame_t;

    frame_t      fq[$];
    logic [31:0] idq[$];
    bit          mon_prev = 1'b1;
    bit          id_prev  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(inout int cyc, output bit ab);
        @(negedge clk);
        cyc++;
        ab = reset;
    endtask

    // Called on the first negedge where the line is low (START cycle 0).
    task automatic frame_check();
        frame_t      e;
        logic [31:0] rx  = '0;
        bit          ok  = 1'b1;
        bit          ab  = 1'b0;
        int          cyc = 0;
        int          div;
        if (fq.size() == 0) begin
            chk("frame_unexpected", 32'd1, 32'd0);
            return;
        end
        e   = fq.pop_front();
        div = e.div;
        for (int c = 1; c < div; c++) begin
            step(cyc, ab);
            if (ab) return;
            if (m_ser_out !== 1'b0) ok = 1'b0;
        end
        for (int b = 31; b >= 0; b--) begin
            for (int c = 0; c < div; c++) begin
                step(cyc, ab);
                if (ab) return;
                if (c == 0) rx[b] = m_ser_out;
                else if (m_ser_out !== rx[b]) ok = 1'b0;
                if (m_done !== 1'b0) ok = 1'b0;
            end
            if (b == 16) chk("busy_mid", m_busy, 32'd1);
        end
`ifdef USER_ID_PARITY_EN
        begin
            logic p = 1'b0;
            for (int c = 0; c < div; c++) begin
                step(cyc, ab);
                if (ab) return;
                if (c == 0) p = m_ser_out;
                else if (m_ser_out !== p) ok = 1'b0;
            end
            chk("parity", p, ^e.word);
        end
`endif
        for (int c = 0; c < div; c++) begin
            step(cyc, ab);
            if (ab) return;
            if (m_ser_out !== 1'b1) ok = 1'b0;
            if (m_done !== 1'b0) ok = 1'b0;
        end
        step(cyc, ab);
        if (ab) return;
        chk("frame_word", rx, e.word);
        chk("frame_shape", ok, 32'd1);
        chk("done_pulse", m_done, 32'd1);
        chk("done_lat", cyc, FRAME_BITS * div);
    endtask

    initial begin : ser_mon
        forever begin
            @(negedge clk);
            if (reset) mon_prev = 1'b1;
            else if (mon_prev && m_ser_out === 1'b0) begin
                frame_check();
                mon_prev = 1'b1;
            end else mon_prev = (m_ser_out !== 1'b0);
        end
    end

    initial begin : id_mon
        forever begin
            @(negedge clk);
            if (!id_prev && ifa.id_valid === 1'b1) begin
                if (idq.size() == 0) chk("id_unexpected", 32'd1, 32'd0);
                else chk("id_data", ifa.id_data, idq.pop_front());
            end
            id_prev = (ifa.id_valid === 1'b1);
        end
    end

    task automatic send(input logic [31:0] w);
        frame_t e;
        e.word = w;
        e.div  = (sel == 0) ? 4 : 1;
        fq.push_back(e);
        if (sel == 0) begin ifa.mask_rev = w; ifa.ser_start = 1'b1; end
        else          begin ifb.mask_rev = w; ifb.ser_start = 1'b1; end
        @(negedge clk);
        ifa.ser_start = 1'b0;
        ifb.ser_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (m_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", (m_done === 1'b1), 32'd1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] w;
        int          cnt;
        ifa.mask_rev = '0; ifa.rd_req = 1'b0; ifa.ser_start = 1'b0;
        ifb.mask_rev = '0; ifb.rd_req = 1'b0; ifb.ser_start = 1'b0;

        // Reset state
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ser_out", ifa.ser_out, 32'd1);
        chk("rst_busy", ifa.ser_busy, 32'd0);
        chk("rst_done", ifa.ser_done, 32'd0);
        chk("rst_id_valid", ifa.id_valid, 32'd0);
        chk("rst_id_data", ifa.id_data, 32'd0);
        chk("rst_b_ser_out", ifb.ser_out, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Reference frame; mask_rev change and a second ser_start mid-frame
        sel = 0;
        send(32'h12092025);
        repeat (20) @(negedge clk);
        ifa.mask_rev  = 32'hDEADBEEF;
        ifa.ser_start = 1'b1;
        @(negedge clk);
        ifa.ser_start = 1'b0;
        wait_done(300);
        chk("shadow_frozen", ifa.id_data, 32'h12092025);
        repeat (4) @(negedge clk);
        chk("no_requeue_busy", ifa.ser_busy, 32'd0);
        chk("idle_line", ifa.ser_out, 32'd1);

        // Random word frames
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            send(w);
            wait_done(300);
            @(negedge clk);
        end

        // Parallel read
        ifa.mask_rev = 32'h12092025;
        ifa.rd_req   = 1'b1;
        idq.push_back(32'h12092025);
        @(negedge clk);
        chk("rd_lat1", ifa.id_valid, 32'd0);
        @(negedge clk);
        chk("rd_lat2", ifa.id_valid, 32'd1);
        chk("rd_hold_busy", ifa.ser_busy, 32'd0);
        ifa.mask_rev  = 32'h0BADF00D;
        ifa.ser_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_frozen", ifa.id_data, 32'h12092025);
        chk("hold_valid", ifa.id_valid, 32'd1);
        chk("hold_no_frame", ifa.ser_out, 32'd1);
        ifa.ser_start = 1'b0;
        ifa.rd_req    = 1'b0;
        @(negedge clk);
        chk("rd_drop", ifa.id_valid, 32'd0);
        @(negedge clk);
        chk("rd_idle_busy", ifa.ser_busy, 32'd0);

        // ser_start and rd_req together: frame first, then the read
        w = 32'hA5C30F96;
        begin
            frame_t e;
            e.word = w;
            e.div  = 4;
            fq.push_back(e);
        end
        idq.push_back(w);
        ifa.mask_rev  = w;
        ifa.ser_start = 1'b1;
        ifa.rd_req    = 1'b1;
        @(negedge clk);
        ifa.ser_start = 1'b0;
        wait_done(300);
        chk("both_valid_idle", ifa.id_valid, 32'd0);
        @(negedge clk);
        chk("both_valid_cap", ifa.id_valid, 32'd0);
        @(negedge clk);
        chk("both_valid_hold", ifa.id_valid, 32'd1);
        ifa.rd_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of bit 10
        send(32'h3C3C5AA5);
        repeat (46) @(negedge clk);
        chk("pre_abort_busy", ifa.ser_busy, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_ser_out", ifa.ser_out, 32'd1);
        chk("abort_busy", ifa.ser_busy, 32'd0);
        chk("abort_done", ifa.ser_done, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifa.ser_done === 1'b1) cnt++;
        end
        chk("abort_nodone", cnt, 32'd0);
        send(32'h12092025);
        wait_done(300);
        @(negedge clk);

        // CLK_DIV = 1 instance
        sel = 1;
        @(negedge clk);
        send(32'hFFFFFFFF);
        wait_done(100);
        @(negedge clk);
        send(32'h12092025);
        wait_done(100);
        repeat (3) @(negedge clk);

        chk("sb_frames_drained", fq.size(), 32'd0);
        chk("sb_ids_drained", idq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/user_id_reader.md
USER_ID_READER -- requirements
Module: user_id_reader

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the serial bit period in clk cycles; legal range 1..255.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port mask_rev  input  32  SHALL carry the tie-cell programmed user project ID.
REQ-005 Port rd_req  input  1  SHALL be the parallel read request, level-sensitive, 4-phase.
REQ-006 Port id_valid  output  1  SHALL acknowledge rd_req with id_data valid.
REQ-007 Port id_data  output  32  SHALL hold the captured ID.
REQ-008 Port ser_start  input  1  SHALL request one serial frame; sampled only in IDLE.
REQ-009 Port ser_out  output  1  SHALL be the serial line; idle high.
REQ-010 Port ser_busy  output  1  SHALL be high in CAPTURE, SHIFT and STOP states.
REQ-011 Port ser_done  output  1  SHALL pulse high for one cycle after the stop bit completes.

Function
REQ-012 FSM states SHALL be IDLE, CAPTURE, START, SHIFT, PARITY (macro only), STOP, HOLD.
REQ-013 IDLE + ser_start=1 -> CAPTURE; IDLE + rd_req=1, ser_start=0 -> CAPTURE; ser_start SHALL win when both are high, and rd_req is then served after the frame.
REQ-014 CAPTURE SHALL last 1 cycle and load mask_rev into a 32-bit shadow register; id_data SHALL always equal the shadow.
REQ-015 Parallel path: CAPTURE -> HOLD; id_valid high from the first HOLD cycle (2 cycles after rd_req rises in IDLE) until the cycle after rd_req falls; then HOLD -> IDLE.
REQ-016 Serial path: CAPTURE -> START; ser_out=0 for CLK_DIV cycles, then SHIFT.
REQ-017 SHIFT SHALL send shadow[31] first, down to shadow[0], each bit for exactly CLK_DIV cycles; a 6-bit bit counter SHALL end SHIFT after 32 bits.
REQ-018 STOP SHALL drive ser_out=1 for CLK_DIV cycles; ser_done SHALL pulse on the first IDLE cycle after STOP.
REQ-019 Frame length SHALL be 34*CLK_DIV cycles, or 35*CLK_DIV with the parity bit.
REQ-020 The ser_start and rd_req inputs SHALL be ignored outside IDLE; no request SHALL be queued except by REQ-013.
REQ-021 CLK_DIV=1: each bit SHALL last one cycle, with no idle cycle between bits.
REQ-022 The shadow SHALL NOT change after CAPTURE, so changes on mask_rev during a frame or HOLD SHALL have no effect.

Reset
REQ-023 While reset is high: FSM=IDLE, shadow=0, id_data=0, id_valid=0, ser_out=1, ser_busy=0, ser_done=0, counters=0.
REQ-024 Reset asserted mid-frame SHALL abort immediately with ser_out=1 and no ser_done pulse.
REQ-025 The first request after reset release SHALL be served normally.

Configuration
REQ-026 Macro USER_ID_PARITY_EN defined: the PARITY state SHALL follow SHIFT and drive the even parity bit (XOR of shadow[31:0]) for CLK_DIV cycles before STOP.
REQ-027 Macro USER_ID_PARITY_EN undefined: SHIFT SHALL go directly to STOP, and no parity logic SHALL be present.

Verification
REQ-028 mask_rev=32'h12092025, CLK_DIV=4, ser_start pulse -> ser_out: 0 for 4 cycles, then bits 0001_0010_0000_1001_0010_0000_0010_0101 at 4 cycles each, then 1; ser_done 136 cycles after START entry (140 with macro, parity bit 0).
REQ-029 Macro defined, mask_rev=32'h00000001 -> parity bit 1, frame length 35*CLK_DIV.
REQ-030 rd_req held high with mask_rev=32'h12092025 -> id_valid rises 2 cycles later, id_data=32'h12092025; rd_req drops -> id_valid low next cycle.
REQ-031 ser_start and rd_req rise in the same cycle -> serial frame completes first, then id_valid rises 2 cycles after return to IDLE.
REQ-032 reset pulsed at bit 10 of a frame -> ser_out=1 and ser_busy=0 immediately, no ser_done; next ser_start gives a full correct frame.
REQ-033 CLK_DIV=1, mask_rev=32'hFFFFFFFF, ser_start pulse -> 0, then 32 ones, then 1; ser_done 34 cycles after START entry.
